uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock (oversample clock, same as receiver side).
REQ-002 SHALL have port reset_n  input  1  reset: asynchronous, active-low.
REQ-003 SHALL have port p_data_in  input  8  parallel byte to transmit.
REQ-004 SHALL have port data_valid_in  input  1  request: p_data_in valid this cycle.
REQ-005 SHALL have port par_en_in  input  1  1 = insert parity bit after data.
REQ-006 SHALL have port par_typ_in  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL have port prescale_in  input  5  clk cycles per bit (legal 4..31).
REQ-008 SHALL have port tx_out  output  1  serial line, idle high.
REQ-009 SHALL have port busy_out  output  1  1 while a frame is in flight.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP, registered state, one-hot or binary encoding free.
REQ-011 SHALL accept a request only in IDLE when data_valid_in=1; on that edge latch p_data_in, par_en_in, par_typ_in, prescale_in and enter START.
REQ-012 SHALL ignore data_valid_in in every state other than IDLE; no queuing.
REQ-013 SHALL treat latched prescale values 0..3 as 4.
REQ-014 SHALL hold each bit on tx_out for exactly P cycles (P = latched prescale) using a bit-period counter 0..P-1 that resets on every bit boundary.
REQ-015 SHALL drive tx_out: IDLE=1, START=0, DATA=latched bit n (LSB first, n=0..7), PARITY=parity bit, STOP=1.
REQ-016 SHALL compute parity over the latched byte: even -> XOR of bits; odd -> inverted XOR.
REQ-017 SHALL transition START->DATA, DATA(bit 7 done)->PARITY if latched par_en=1 else STOP, PARITY->STOP, STOP->IDLE, each at counter = P-1.
REQ-018 SHALL register tx_out and busy_out (no combinational path from inputs).
REQ-019 SHALL drive tx_out low and busy_out high in the cycle after acceptance (latency 1).
REQ-020 SHALL keep busy_out high for exactly 10*P cycles without parity, 11*P with parity, and low in IDLE.
REQ-021 SHALL allow a new acceptance in the first IDLE cycle, giving a minimum one-cycle high gap plus the stop bit between frames.
REQ-022 SHALL be unaffected by changes of p_data_in, par_en_in, par_typ_in, prescale_in during a frame.
REQ-023 SHALL return to IDLE on any illegal state encoding.

Reset
REQ-024 SHALL on reset_n=0 force state IDLE, counters 0, latched data 0, tx_out=1, busy_out=0, asynchronously.
REQ-025 SHALL abort a frame in progress on reset mid-operation, with tx_out returning high immediately.

Configuration
REQ-026 SHALL support macro UART_TX_PARITY_EN: defined -> parity per REQ-016/017; undefined -> PARITY state and parity logic omitted, par_en_in/par_typ_in ignored, frame always 10*P cycles.

Verification
REQ-027 SHALL cover: P=8, par_en=0, byte 0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1 each 8 cycles; busy 80 cycles.
REQ-028 SHALL cover: P=8, par_en=1, par_typ=0, byte 0x07 -> parity bit 1; busy 88 cycles (macro defined).
REQ-029 SHALL cover: P=16, par_en=1, par_typ=1, byte 0xFF -> parity bit 1; busy 176 cycles.
REQ-030 SHALL cover: data_valid_in held high continuously with bytes 0x01,0x02 -> two frames, busy drops exactly 1 cycle between them, second byte is value present at IDLE.
REQ-031 SHALL cover: reset_n pulsed low during DATA bit 3 -> tx_out=1, busy_out=0 same cycle; next request transmits a full clean frame.
REQ-032 SHALL cover: prescale_in=2 at acceptance -> each bit lasts 4 cycles; prescale_in changed to 8 mid-frame -> no effect.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Optional parity support is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] p_data_in,
  input  logic       data_valid_in,
  input  logic       par_en_in,
  input  logic       par_typ_in,
  input  logic [4:0] prescale_in,
  output logic       tx_out,
  output logic       busy_out
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t     state_reg, state_next;
  logic [4:0] cnt_reg, cnt_next;
  logic [2:0] bit_reg, bit_next;
  logic [7:0] data_reg;
  logic [4:0] prescale_reg;
  logic       load;
  logic       last_cnt;
  logic       tx_next;
  logic       busy_next;

`ifdef UART_TX_PARITY_EN
  logic par_en_reg;
  logic par_typ_reg;
  logic par_bit;

  assign par_bit = (^data_reg) ^ par_typ_reg;
`else
  // Parity inputs have no function in this build.
  logic unused_par;

  assign unused_par = par_en_in ^ par_typ_in;
`endif

  assign last_cnt = (cnt_reg == (prescale_reg - 5'd1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 5'd1;
    bit_next   = bit_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = 5'd0;
        bit_next = 3'd0;
        if (data_valid_in) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (last_cnt) begin
          cnt_next   = 5'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (last_cnt) begin
          cnt_next = 5'd0;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = par_en_reg ? PARITY : STOP;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last_cnt) begin
          cnt_next   = 5'd0;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (last_cnt) begin
          cnt_next   = 5'd0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = 5'd0;
        bit_next   = 3'd0;
        state_next = IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so tx_out/busy_out stay registered.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[bit_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_bit;
`endif
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      bit_reg      <= 3'd0;
      data_reg     <= 8'd0;
      prescale_reg <= 5'd0;
      tx_out       <= 1'b1;
      busy_out     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_out    <= tx_next;
      busy_out  <= busy_next;
      if (load) begin
        data_reg     <= p_data_in;
        prescale_reg <= (prescale_in < 5'd4) ? 5'd4 : prescale_in;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
    end else if (load) begin
      par_en_reg  <= par_en_in;
      par_typ_reg <= par_typ_in;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a negedge monitor checks the line.
// Parity expectations follow whether UART_TX_PARITY_EN is defined.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] p_data_in;
  logic       data_valid_in;
  logic       par_en_in;
  logic       par_typ_in;
  logic [4:0] prescale_in;
  logic       tx_out;
  logic       busy_out;

  uart_tx dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .p_data_in     (p_data_in),
    .data_valid_in (data_valid_in),
    .par_en_in     (par_en_in),
    .par_typ_in    (par_typ_in),
    .prescale_in   (prescale_in),
    .tx_out        (tx_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;   // bits[0] is the first bit on the line
    int          nbits;
    int          p;
    int          gap;    // required idle cycles before this frame, -1 = don't care
    logic [7:0]  byte_v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   active = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input bit pen, input bit par, input int p, input int gap);
    exp_t e;
    e.bits      = 11'h7FF;
    e.bits[0]   = 1'b0;
    e.bits[8:1] = d;
    e.nbits     = 10;
    if (pen && PAR_BUILD) begin
      e.bits[9] = par;
      e.nbits   = 11;
    end
    e.p      = p;
    e.gap    = gap;
    e.byte_v = d;
    return e;
  endfunction

  // Monitor: one check of busy and line level per cycle of an active frame.
  exp_t cur;
  int   cyc;
  int   idle_cnt = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      if (active) $display("frame byte=0x%02h aborted by reset at cycle %0d", cur.byte_v, cyc);
      active   = 1'b0;
      idle_cnt = 0;
    end else begin
      if (!active) begin
        if (busy_out) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            cur    = sb_q.pop_front();
            active = 1'b1;
            cyc    = 0;
            if (cur.gap >= 0) chk("frame_gap", idle_cnt, cur.gap);
          end
        end else begin
          chk("idle_tx", tx_out, 1);
          idle_cnt++;
        end
      end
      if (active) begin
        if (cyc < cur.nbits * cur.p) begin
          chk("busy_in_frame", busy_out, 1);
          chk("tx_bit", tx_out, cur.bits[cyc / cur.p]);
          cyc++;
        end else begin
          chk("busy_end", busy_out, 0);
          chk("line_idle_after", tx_out, 1);
          $display("frame byte=0x%02h P=%0d bits=%0d busy=%0d cycles", cur.byte_v, cur.p, cur.nbits, cyc);
          active   = 1'b0;
          idle_cnt = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (busy_out) chk("idle_timeout", 1, 0);
  endtask

  // Called at posedge+2; returns at posedge+2 of the acceptance edge.
  task automatic send(input logic [7:0] d, input bit pen, input bit ptyp, input logic [4:0] pres,
                      input bit exp_par, input int exp_p);
    wait_idle();
    p_data_in     = d;
    par_en_in     = pen;
    par_typ_in    = ptyp;
    prescale_in   = pres;
    data_valid_in = 1'b1;
    sb_q.push_back(mk(d, pen, exp_par, exp_p, -1));
    @(posedge clk); #2;
    data_valid_in = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    p_data_in     = 8'h00;
    data_valid_in = 1'b0;
    par_en_in     = 1'b0;
    par_typ_in    = 1'b0;
    prescale_in   = 5'd8;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx", tx_out, 1);
    chk("reset_busy", busy_out, 0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    // 0xA5, no parity: line 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 5'd8, 1'b0, 8);
    // 0x07 even parity: three ones -> parity bit 1
    send(8'h07, 1'b1, 1'b0, 5'd8, 1'b1, 8);
    // 0xFF odd parity: eight ones -> parity bit 1
    send(8'hFF, 1'b1, 1'b1, 5'd16, 1'b1, 16);

    // Back-to-back with valid held high; second byte is whatever is present at IDLE
    wait_idle();
    p_data_in     = 8'h01;
    par_en_in     = 1'b0;
    prescale_in   = 5'd8;
    data_valid_in = 1'b1;
    sb_q.push_back(mk(8'h01, 1'b0, 1'b0, 8, -1));
    sb_q.push_back(mk(8'h02, 1'b0, 1'b0, 8, 1));
    @(posedge clk); #2;
    p_data_in = 8'h02;
    wait_idle();
    @(posedge clk); #2;
    data_valid_in = 1'b0;

    // Prescale 2 clamps to 4; mid-frame input changes have no effect
    send(8'h5A, 1'b0, 1'b0, 5'd2, 1'b0, 4);
    prescale_in = 5'd8;
    p_data_in   = 8'hFF;
    par_en_in   = 1'b1;
    par_typ_in  = 1'b1;

    // Reset during data bit 3 (0x35 has bit 3 = 0, so the line must jump high)
    send(8'h35, 1'b0, 1'b0, 5'd8, 1'b0, 8);
    repeat (34) @(posedge clk);
    #1;
    chk("pre_reset_tx", tx_out, 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_tx", tx_out, 1);
    chk("abort_busy", busy_out, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    send(8'h35, 1'b0, 1'b0, 5'd8, 1'b0, 8);

    begin
      int n = 0;
      while ((sb_q.size() != 0 || active) && n < 2000) begin
        @(posedge clk);
        n++;
      end
    end
    chk("scoreboard_drained", sb_q.size() + int'(active), 0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
